// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and one-entry skid buffer
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STALL,
  input  logic              BRANCH_TAKEN,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [DATA_W-1:0] IMEM_RDATA,
  output logic              IF_VALID,
  output logic [DATA_W-1:0] IF_INSTR,
  output logic [ADDR_W-1:0] IF_PC_PLUS4,
  output logic [5:0]        OPCODE,
  output logic [31:0]       FETCH_COUNT
);

  typedef enum logic [1:0] {IDLE, REQ, SKID} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   redir_q, redir_d;
  logic                kill_q, kill_d;
  logic [DATA_W-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]   skid_pc4_q, skid_pc4_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]   if_pc4_q, if_pc4_d;
  logic [31:0]         count_q, count_d;

  logic                load;
  logic [DATA_W-1:0]   load_instr;
  logic [ADDR_W-1:0]   load_pc4;
  logic [ADDR_W-1:0]   pc_plus4;
  logic                if_free;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign if_free  = !if_valid_q || !STALL;

  // Next-state logic: fetch sequencing, redirect handling and IF/ID update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    kill_d       = kill_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc4_d     = if_pc4_q;
    count_d      = count_q;
    load         = 1'b0;
    load_instr   = IMEM_RDATA;
    load_pc4     = pc_plus4;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (BRANCH_TAKEN) begin
          if (IMEM_ACK) begin
            // Response in flight belongs to the wrong path; drop it and refetch.
            pc_d   = BRANCH_TARGET;
            kill_d = 1'b0;
          end else begin
            // Address must stay stable until ACK, so park the target.
            redir_d = BRANCH_TARGET;
            kill_d  = 1'b1;
          end
        end else if (IMEM_ACK) begin
          if (kill_q) begin
            pc_d   = redir_q;
            kill_d = 1'b0;
          end else begin
            pc_d = pc_plus4;
            if (if_free) begin
              load = 1'b1;
            end else begin
              skid_instr_d = IMEM_RDATA;
              skid_pc4_d   = pc_plus4;
              state_d      = SKID;
            end
          end
        end
      end
      SKID: begin
        if (BRANCH_TAKEN) begin
          pc_d    = BRANCH_TARGET;
          state_d = REQ;
        end else if (!STALL) begin
          load       = 1'b1;
          load_instr = skid_instr_q;
          load_pc4   = skid_pc4_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (BRANCH_TAKEN && state_q != IDLE) begin
      if_valid_d = 1'b0;
      if_instr_d = '0;
    end else if (load) begin
      if_valid_d = 1'b1;
      if_instr_d = load_instr;
      if_pc4_d   = load_pc4;
      count_d    = count_q + 32'd1;
    end else if (!STALL) begin
      if_valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_q      <= '0;
      kill_q       <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc4_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_q      <= redir_d;
      kill_q       <= kill_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc4_q     <= if_pc4_d;
      count_q      <= count_d;
    end
  end

  assign IMEM_REQ    = RST_N && (state_q == REQ);
  assign IMEM_ADDR   = pc_q;
  assign IF_VALID    = if_valid_q;
  assign IF_INSTR    = if_instr_q;
  assign IF_PC_PLUS4 = if_pc4_q;
  assign OPCODE      = if_instr_q[DATA_W-1 -: 6];
  assign FETCH_COUNT = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a queue-based reference model
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        IF_VALID;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC_PLUS4;
  logic [5:0]  OPCODE;
  logic [31:0] FETCH_COUNT;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC_PLUS4(IF_PC_PLUS4),
    .OPCODE(OPCODE), .FETCH_COUNT(FETCH_COUNT)
  );

  always #5 CLK = ~CLK;

  // Reference model: the next fetch address, a pending redirect, a waiting-word queue and the IF/ID slot.
  typedef struct {logic [31:0] instr; logic [31:0] pc4;} ent_t;
  ent_t        waitq[$];
  logic [31:0] m_pc = 0, m_redir = 0, m_instr = 0, m_pc4 = 0, m_cnt = 0;
  bit          m_kill = 0, m_live = 0, m_v = 0;

  function automatic bit m_req();
    return m_live && waitq.size() == 0;
  endfunction

  function automatic void model_edge(bit rstn, bit stall, bit br, logic [31:0] tgt, bit ack, logic [31:0] rdata);
    bit          got = 0;
    logic [31:0] w = 0, a = 0;
    if (!rstn) begin
      m_pc = 0; m_redir = 0; m_kill = 0; m_live = 0; waitq.delete();
      m_v = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0;
      return;
    end
    if (!m_live) begin
      m_live = 1;
      return;
    end
    if (br) begin
      m_v = 0; m_instr = 0;
      if (waitq.size() != 0) begin
        waitq.delete(); m_pc = tgt;
      end else if (ack) begin
        m_pc = tgt; m_kill = 0;
      end else begin
        m_redir = tgt; m_kill = 1;
      end
      return;
    end
    if (waitq.size() == 0 && ack) begin
      if (m_kill) begin
        m_pc = m_redir; m_kill = 0;
      end else begin
        a = m_pc + 4;
        m_pc = a;
        if (!m_v || !stall) begin got = 1; w = rdata; end
        else waitq.push_back('{rdata, a});
      end
    end else if (waitq.size() != 0 && !stall) begin
      got = 1; w = waitq[0].instr; a = waitq[0].pc4; waitq.pop_front();
    end
    if (got) begin
      m_v = 1; m_instr = w; m_pc4 = a; m_cnt = m_cnt + 1;
    end else if (!stall) begin
      m_v = 0;
    end
  endfunction

  task automatic tick(input bit rstn, input bit stall, input bit br, input logic [31:0] tgt,
                      input bit ack, input logic [31:0] rdata);
    RST_N = rstn; STALL = stall; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
    IMEM_ACK = ack; IMEM_RDATA = rdata;
    @(posedge CLK);
    model_edge(rstn, stall, br, tgt, ack, rdata);
    #1;
    IMEM_ACK = 1'b0; BRANCH_TAKEN = 1'b0;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    total++;
    if ({IMEM_REQ, IF_VALID, IF_INSTR, IF_PC_PLUS4, OPCODE, FETCH_COUNT} !== '0) begin
      bad++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h pc4=%h op=%b cnt=%0d required all zero",
               IMEM_REQ, IF_VALID, IF_INSTR, IF_PC_PLUS4, OPCODE, FETCH_COUNT);
    end
    total++;
    if (IMEM_ADDR !== 32'h0) begin
      bad++; $display("FAIL reset_pc: addr=%h required 00000000", IMEM_ADDR);
    end
  endtask

  task automatic test_stream();
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 32'(i * 4)}) begin
        bad++; $display("FAIL stream_addr%0d: req=%b addr=%h required 1/%h", i, IMEM_REQ, IMEM_ADDR, i * 4);
      end
      tick(1, 0, 0, 0, 1, 32'hA000_0000 | 32'(i * 4));
      total++;
      if ({IF_VALID, IF_INSTR, IF_PC_PLUS4, FETCH_COUNT} !==
          {1'b1, 32'hA000_0000 | 32'(i * 4), 32'(i * 4 + 4), 32'(i + 1)}) begin
        bad++;
        $display("FAIL stream_ifid%0d: valid=%b instr=%h pc4=%h cnt=%0d required 1/%h/%h/%0d", i,
                 IF_VALID, IF_INSTR, IF_PC_PLUS4, FETCH_COUNT, 32'hA000_0000 | 32'(i * 4), i * 4 + 4, i + 1);
      end
    end
  endtask

  task automatic test_delayed_ack();
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      total++;
      if ({IMEM_REQ, IMEM_ADDR, IF_VALID} !== {1'b1, 32'h0, 1'b0}) begin
        bad++; $display("FAIL wait_hold%0d: req=%b addr=%h valid=%b required 1/0/0", i, IMEM_REQ, IMEM_ADDR, IF_VALID);
      end
    end
    tick(1, 0, 0, 0, 1, 32'h0000_0020);
    total++;
    if ({IF_VALID, OPCODE, IF_PC_PLUS4, IF_INSTR, FETCH_COUNT} !== {1'b1, 6'b0, 32'h4, 32'h20, 32'd1}) begin
      bad++;
      $display("FAIL delayed_ack: valid=%b op=%b pc4=%h instr=%h cnt=%0d required 1/000000/4/20/1",
               IF_VALID, OPCODE, IF_PC_PLUS4, IF_INSTR, FETCH_COUNT);
    end
  endtask

  task automatic test_skid();
    tick(1, 1, 0, 0, 1, 32'h8C01_0004);
    total++;
    if ({IMEM_REQ, IF_VALID, IF_INSTR, FETCH_COUNT} !== {1'b0, 1'b1, 32'h20, 32'd1}) begin
      bad++; $display("FAIL skid_enter: req=%b valid=%b instr=%h cnt=%0d required 0/1/20/1",
                      IMEM_REQ, IF_VALID, IF_INSTR, FETCH_COUNT);
    end
    tick(1, 1, 0, 0, 0, 0);
    total++;
    if ({IMEM_REQ, IF_INSTR} !== {1'b0, 32'h20}) begin
      bad++; $display("FAIL skid_hold: req=%b instr=%h required 0/20", IMEM_REQ, IF_INSTR);
    end
    tick(1, 0, 0, 0, 0, 0);
    total++;
    if ({IF_VALID, IF_INSTR, OPCODE, IF_PC_PLUS4, FETCH_COUNT, IMEM_REQ, IMEM_ADDR} !==
        {1'b1, 32'h8C01_0004, 6'b100011, 32'h8, 32'd2, 1'b1, 32'h8}) begin
      bad++;
      $display("FAIL skid_release: valid=%b instr=%h op=%b pc4=%h cnt=%0d req=%b addr=%h required 1/8c010004/100011/8/2/1/8",
               IF_VALID, IF_INSTR, OPCODE, IF_PC_PLUS4, FETCH_COUNT, IMEM_REQ, IMEM_ADDR);
    end
  endtask

  task automatic test_redirect_pending();
    tick(1, 0, 1, 32'h40, 0, 0);
    total++;
    if ({IF_VALID, IMEM_REQ, IMEM_ADDR, OPCODE} !== {1'b0, 1'b1, 32'h8, 6'b0}) begin
      bad++; $display("FAIL redir_latch: valid=%b req=%b addr=%h op=%b required 0/1/8/000000",
                      IF_VALID, IMEM_REQ, IMEM_ADDR, OPCODE);
    end
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    total++;
    if ({IF_VALID, FETCH_COUNT, IMEM_ADDR} !== {1'b0, 32'd2, 32'h40}) begin
      bad++; $display("FAIL redir_kill: valid=%b cnt=%0d addr=%h required 0/2/40", IF_VALID, FETCH_COUNT, IMEM_ADDR);
    end
    tick(1, 0, 0, 0, 1, 32'h0000_0011);
    total++;
    if ({IF_VALID, IF_INSTR, IF_PC_PLUS4, FETCH_COUNT, IMEM_ADDR} !== {1'b1, 32'h11, 32'h44, 32'd3, 32'h44}) begin
      bad++; $display("FAIL redir_resume: valid=%b instr=%h pc4=%h cnt=%0d addr=%h required 1/11/44/3/44",
                      IF_VALID, IF_INSTR, IF_PC_PLUS4, FETCH_COUNT, IMEM_ADDR);
    end
  endtask

  task automatic test_branch_in_skid();
    tick(1, 1, 0, 0, 1, 32'h0000_0022);
    tick(1, 1, 1, 32'h80, 0, 0);
    total++;
    if ({IF_VALID, IMEM_REQ, IMEM_ADDR, FETCH_COUNT} !== {1'b0, 1'b1, 32'h80, 32'd3}) begin
      bad++; $display("FAIL skid_flush: valid=%b req=%b addr=%h cnt=%0d required 0/1/80/3",
                      IF_VALID, IMEM_REQ, IMEM_ADDR, FETCH_COUNT);
    end
    tick(1, 0, 0, 0, 0, 0);
    total++;
    if ({IF_VALID, FETCH_COUNT} !== {1'b0, 32'd3}) begin
      bad++; $display("FAIL skid_no_stale: valid=%b cnt=%0d required 0/3", IF_VALID, FETCH_COUNT);
    end
    tick(1, 0, 0, 0, 1, 32'h0000_0033);
    total++;
    if ({IF_VALID, IF_INSTR, IF_PC_PLUS4, FETCH_COUNT} !== {1'b1, 32'h33, 32'h84, 32'd4}) begin
      bad++; $display("FAIL skid_target_fetch: valid=%b instr=%h pc4=%h cnt=%0d required 1/33/84/4",
                      IF_VALID, IF_INSTR, IF_PC_PLUS4, FETCH_COUNT);
    end
  endtask

  task automatic test_reset_midreq();
    RST_N = 1'b0;
    #1;
    total++;
    if (IMEM_REQ !== 1'b0) begin
      bad++; $display("FAIL reset_req_drop: req=%b required 0", IMEM_REQ);
    end
    tick(0, 0, 0, 0, 1, 32'h0000_0055);
    total++;
    if ({IMEM_REQ, IF_VALID, FETCH_COUNT, IMEM_ADDR, IF_INSTR} !== {1'b0, 1'b0, 32'd0, 32'h0, 32'h0}) begin
      bad++; $display("FAIL reset_midreq: req=%b valid=%b cnt=%0d addr=%h instr=%h required 0/0/0/0/0",
                      IMEM_REQ, IF_VALID, FETCH_COUNT, IMEM_ADDR, IF_INSTR);
    end
    tick(1, 0, 0, 0, 0, 0);
    total++;
    if ({IMEM_REQ, IMEM_ADDR, IF_VALID} !== {1'b1, 32'h0, 1'b0}) begin
      bad++; $display("FAIL reset_restart: req=%b addr=%h valid=%b required 1/0/0", IMEM_REQ, IMEM_ADDR, IF_VALID);
    end
  endtask

  task automatic test_wrap();
    tick(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h1234_5678);
    total++;
    if ({IMEM_ADDR, IF_VALID} !== {32'hFFFF_FFFC, 1'b0}) begin
      bad++; $display("FAIL wrap_redirect: addr=%h valid=%b required fffffffc/0", IMEM_ADDR, IF_VALID);
    end
    tick(1, 0, 0, 0, 1, 32'hFC00_ABCD);
    total++;
    if ({IF_PC_PLUS4, IMEM_ADDR, IF_INSTR, OPCODE, FETCH_COUNT} !== {32'h0, 32'h0, 32'hFC00_ABCD, 6'b111111, 32'd1}) begin
      bad++; $display("FAIL wrap_pc: pc4=%h addr=%h instr=%h op=%b cnt=%0d required 0/0/fc00abcd/111111/1",
                      IF_PC_PLUS4, IMEM_ADDR, IF_INSTR, OPCODE, FETCH_COUNT);
    end
  endtask

  task automatic test_random();
    bit          rstn, stall, br, ack;
    logic [31:0] tgt, rd;
    for (int i = 0; i < 3000; i++) begin
      rstn  = ($urandom_range(0, 99) != 0);
      stall = ($urandom_range(0, 9) < 4);
      br    = ($urandom_range(0, 9) == 0);
      tgt   = $urandom & 32'hFFFF_FFFC;
      ack   = m_req() && ($urandom_range(0, 9) < 6);
      rd    = $urandom;
      tick(rstn, stall, br, tgt, ack, rd);
      total++;
      if (IMEM_REQ !== (rstn && m_req())) begin
        bad++; $display("FAIL rand_req@%0d: got=%b required %b", i, IMEM_REQ, rstn && m_req());
      end
      total++;
      if (IMEM_ADDR !== m_pc) begin
        bad++; $display("FAIL rand_addr@%0d: got=%h required %h", i, IMEM_ADDR, m_pc);
      end
      total++;
      if ({IF_VALID, IF_INSTR, IF_PC_PLUS4} !== {m_v, m_instr, m_pc4}) begin
        bad++; $display("FAIL rand_ifid@%0d: got=%b/%h/%h required %b/%h/%h", i,
                        IF_VALID, IF_INSTR, IF_PC_PLUS4, m_v, m_instr, m_pc4);
      end
      total++;
      if (OPCODE !== m_instr[31:26]) begin
        bad++; $display("FAIL rand_opcode@%0d: got=%b required %b", i, OPCODE, m_instr[31:26]);
      end
      total++;
      if (FETCH_COUNT !== m_cnt) begin
        bad++; $display("FAIL rand_count@%0d: got=%0d required %0d", i, FETCH_COUNT, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_delayed_ack();
    test_skid();
    test_redirect_pending();
    test_branch_in_skid();
    test_reset_midreq();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the single-issue MIPS datapath. It drives the program counter and runs a request/acknowledge handshake with instruction memory. It holds the fetched word in IF/ID and presents its opcode field to the control decoder in the ID stage. It supports a downstream stall, branch redirect with flush, and a one-entry skid buffer so memory responses are never dropped.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset; address of the first fetch.
ADDR_W, 32, PC and IMEM address width.
DATA_W, 32, instruction width; the opcode is always bits [DATA_W-1:DATA_W-6].

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  reset, synchronous, active-low.
STALL  in  1  ID stage cannot consume IF/ID this cycle.
BRANCH_TAKEN  in  1  redirect fetch to BRANCH_TARGET and flush IF/ID.
BRANCH_TARGET  in  ADDR_W  redirect address, word aligned.
IMEM_REQ  out  1  fetch request.
IMEM_ADDR  out  ADDR_W  fetch address.
IMEM_ACK  in  1  memory completes the current request this cycle.
IMEM_RDATA  in  DATA_W  instruction word, valid when IMEM_ACK is high.
IF_VALID  out  1  IF/ID holds a valid instruction.
IF_INSTR  out  DATA_W  IF/ID instruction.
IF_PC_PLUS4  out  ADDR_W  address of the IF/ID instruction plus 4.
OPCODE  out  6  IF_INSTR[DATA_W-1:DATA_W-6], feeds the control decoder.
FETCH_COUNT  out  32  instructions written into IF/ID since reset, wraps.

Behaviour:
- Reset: sampled on the CLK rising edge while RST_N=0. It sets PC=RESET_PC, state=IDLE, IF_VALID=0, IF_INSTR=0, IF_PC_PLUS4=0, FETCH_COUNT=0, skid buffer empty, kill flag clear. IMEM_REQ=0 while RST_N=0.
- Reset asserted mid-request abandons the request; memory must drop it on IMEM_REQ falling.
- States:
  - IDLE: entered only by reset; moves to REQ on the first edge with RST_N=1.
  - REQ: IMEM_REQ=1, IMEM_ADDR=PC, both stable until IMEM_ACK.
  - SKID: IMEM_REQ=0; a response is buffered.
- Handshake: IMEM_ACK is legal in any REQ cycle, including the first. Only one request is outstanding at a time.
- An ACK in REQ without kill and without BRANCH_TAKEN is an accept:
  - PC<=PC+4.
  - If IF/ID can load (IF_VALID=0 or STALL=0): IF_INSTR<=RDATA, IF_PC_PLUS4<=PC+4, IF_VALID<=1, FETCH_COUNT++, stay in REQ. Back-to-back ACKs give one instruction per cycle.
  - Otherwise the word and PC+4 go to the skid buffer and the state moves to SKID.
- SKID: when STALL=0, the skid contents load into IF/ID, FETCH_COUNT++, and the state moves to REQ.
- IF/ID with no new load: if STALL=0, IF_VALID<=0 (consumed); if STALL=1, hold all fields.
- Redirect (BRANCH_TAKEN=1) has priority over STALL and over loads. At the next edge, IF_VALID<=0 and the skid buffer is discarded.
  - In REQ with ACK the same cycle: discard RDATA, PC<=BRANCH_TARGET, stay in REQ.
  - In REQ without ACK: latch the target into the redirect register and set kill; IMEM_ADDR does not change.
  - In SKID: PC<=BRANCH_TARGET, move to REQ.
  - A second BRANCH_TAKEN while kill is set overwrites the latched target.
- On ACK with kill set: discard RDATA, PC<=latched target, clear kill, stay in REQ, FETCH_COUNT unchanged.
- Arithmetic: PC+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 wraps to 0. FETCH_COUNT wraps at 2^32.
- Latency: an ACK at edge n makes IF_VALID=1 and OPCODE valid after edge n, when IF/ID is free.
- OPCODE is combinational from IF_INSTR and reads 6'b000000 after reset or flush.

Test Plan:
1. Release reset with RESET_PC=0 and memory acking every cycle with RDATA=addr-derived words -> IMEM_ADDR steps 0,4,8,C. IF_PC_PLUS4 steps 4,8,C,10. FETCH_COUNT increments by one per cycle.
2. Memory acks after 3 cycles with RDATA=32'h0000_0020 -> IMEM_ADDR stays 0 for 3 cycles, then IF_VALID=1, OPCODE=6'b000000, IF_PC_PLUS4=4.
3. STALL=1 with IF/ID valid, then ACK with RDATA=32'h8C01_0004 -> state SKID, IMEM_REQ=0, IF_INSTR unchanged. Release STALL -> IF_INSTR=32'h8C01_0004, OPCODE=6'b100011.
4. BRANCH_TAKEN with target 32'h40 pulsed 2 cycles before a delayed ACK -> acked data discarded, next IMEM_ADDR=32'h40, IF_VALID=0 over the gap, FETCH_COUNT unchanged.
5. BRANCH_TAKEN in SKID with STALL=1 -> IF_VALID=0 and skid discarded next edge; IMEM_ADDR equals the target; no stale instruction reaches IF/ID.
6. RST_N=0 asserted while REQ is pending -> next edge IMEM_REQ=0, IF_VALID=0, FETCH_COUNT=0, PC=RESET_PC. A late ACK during reset is ignored.
